// File: rtl/opcond_pkg.sv
`default_nettype none
// ============================================================================
// Module      : opcond_pkg
// Description : Mode codes, FSM states and mode decode helpers shared by the
//               operand conditioner.
// Revision    : 1.0 - initial release
// ============================================================================
package opcond_pkg;

    localparam logic [1:0] MODE_PASS = 2'b00;
    localparam logic [1:0] MODE_INV  = 2'b01;
    localparam logic [1:0] MODE_NEG  = 2'b10;
    localparam logic [1:0] MODE_ABS  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // True when the operand is two's-complement negated (NEG, or ABS of a negative value)
    function automatic logic mode_negates(input logic [1:0] mode, input logic msb);
        return (mode == MODE_NEG) || ((mode == MODE_ABS) && msb);
    endfunction

    function automatic logic mode_inverts(input logic [1:0] mode, input logic msb);
        return (mode == MODE_INV) || mode_negates(mode, msb);
    endfunction

endpackage
`default_nettype wire

// File: rtl/operand_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module      : operand_conditioner_if
// Description : Valid/ready operand and result channels of the conditioner.
// Revision    : 1.0 - initial release
// ============================================================================
interface operand_conditioner_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic             out_carry;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_mode, out_ready,
        input  in_ready, out_valid, out_y, out_carry, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_mode, out_ready,
        output in_ready, out_valid, out_y, out_carry, out_ovf
    );
endinterface
`default_nettype wire

// File: rtl/opcond_slice.sv
`default_nettype none
// ============================================================================
// Module      : opcond_slice
// Description : One CHUNK-bit slice: optional invert followed by carry add.
// Revision    : 1.0 - initial release
// ============================================================================
module opcond_slice #(
    parameter int CHUNK = 4
) (
    input  wire logic [CHUNK-1:0] a,
    input  wire logic             inv,
    input  wire logic             c_in,
    output logic      [CHUNK-1:0] y,
    output logic                  c_out
);

    logic [CHUNK-1:0] w_s;

    assign w_s          = a ^ {CHUNK{inv}};
    assign {c_out, y}   = {1'b0, w_s} + {{CHUNK{1'b0}}, c_in};

endmodule
`default_nettype wire

// File: rtl/operand_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : operand_conditioner
// Description : Multi-cycle PASS/INV/NEG/ABS operand conditioner processing
//               one CHUNK-bit slice per cycle (WIDTH must be a multiple of CHUNK).
// Revision    : 1.0 - initial release
// ============================================================================
module operand_conditioner
    import opcond_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  wire logic            clk,
    input  wire logic            rst,
    operand_conditioner_if.slave bus
);

    localparam int c_n_slices = WIDTH / CHUNK;
    localparam int c_idx_w    = (c_n_slices > 1) ? $clog2(c_n_slices) : 1;
    localparam int c_base_w   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_idx_w-1:0] c_last_idx  = c_idx_w'(c_n_slices - 1);
    localparam logic [WIDTH-1:0]   c_most_neg  = {1'b1, {(WIDTH-1){1'b0}}};

    state_t             r_state;
    logic [c_idx_w-1:0] r_idx;
    logic [WIDTH-1:0]   r_opnd;
    logic               r_inv;
    logic               r_carry;
    logic               r_ovf_pend;
    logic [WIDTH-1:0]   r_work;
    logic [WIDTH-1:0]   r_y;
    logic               r_carry_out;
    logic               r_ovf;
    logic               r_in_ready;
    logic               r_out_valid;

    logic [c_base_w-1:0] w_base;
    logic [CHUNK-1:0]    w_slice_a;
    logic [CHUNK-1:0]    w_slice_y;
    logic                w_slice_c;
    logic [WIDTH-1:0]    w_work_next;
    logic                w_negates;
    logic                w_inverts;
    logic                w_ovf_in;

    assign w_negates = mode_negates(bus.in_mode, bus.in_a[WIDTH-1]);
    assign w_inverts = mode_inverts(bus.in_mode, bus.in_a[WIDTH-1]);
    assign w_ovf_in  = w_negates && (bus.in_a == c_most_neg);

    assign w_base    = c_base_w'(int'(r_idx) * CHUNK);
    assign w_slice_a = r_opnd[w_base +: CHUNK];

    opcond_slice #(
        .CHUNK (CHUNK)
    ) u_slice (
        .a     (w_slice_a),
        .inv   (r_inv),
        .c_in  (r_carry),
        .y     (w_slice_y),
        .c_out (w_slice_c)
    );

    // Partial result with the current slice merged in; becomes out_y after the last slice
    always_comb begin
        w_work_next                   = r_work;
        w_work_next[w_base +: CHUNK]  = w_slice_y;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_opnd      <= '0;
            r_inv       <= 1'b0;
            r_carry     <= 1'b0;
            r_ovf_pend  <= 1'b0;
            r_work      <= '0;
            r_y         <= '0;
            r_carry_out <= 1'b0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_opnd     <= bus.in_a;
                        r_inv      <= w_inverts;
                        r_carry    <= w_negates;
                        r_ovf_pend <= w_ovf_in;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    r_work  <= w_work_next;
                    r_carry <= w_slice_c;
                    if (r_idx == c_last_idx) begin
                        r_y         <= w_work_next;
                        r_carry_out <= w_slice_c;
                        r_ovf       <= r_ovf_pend;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + c_idx_w'(1);
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_y     = r_y;
    assign bus.out_carry = r_carry_out;
    assign bus.out_ovf   = r_ovf;

endmodule
`default_nettype wire
